// File: rtl/display_scan_controller.sv
// Purpose : time-multiplexed scan of a 3-digit BCD 7-segment display with blank guard slots.
// Latency : seg/selected/frame_start are registered; a new value appears at the next frame boundary (or next cycle in IDLE).
// Backpressure: load_ready low while a value waits in the pending register; one value buffered.
// Ports   : clk, rst_n (async active-low), enable, blank_lz, load_valid/load_data/load_ready (12-bit BCD
//           value handshake), selected (0 ones, 1 tens, 2 hundreds, 3 off), seg (active-low {g..a}), frame_start.
module display_scan_controller #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic        load_valid,
    input  logic [11:0] load_data,
    output logic        load_ready,
    output logic [1:0]  selected,
    output logic [6:0]  seg,
    output logic        frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SLOT_LAST  = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [11:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [11:0]   active_q, active_d;
    logic [1:0]    sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic          fs_q, fs_d;
    logic          accept, copy;
    logic [3:0]    nib;
    logic          lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;   // non-BCD nibble shows a dash
        endcase
    endfunction

    // Slot sequencing: counter runs 0..REFRESH_DIV-1 across BLANK then SHOW.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        fs_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                digit_d = 2'd0;
                if (enable) begin
                    state_d = BLANK;
                    fs_d    = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_BLANK_LAST) state_d = SHOW;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                end else if (cnt_q == CNT_SLOT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (digit_q == 2'd2) begin
                        digit_d = 2'd0;
                        fs_d    = 1'b1;   // wrap back to ones is the frame boundary
                    end else begin
                        digit_d = digit_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                digit_d = 2'd0;
            end
        endcase
    end

    // Pending -> active copy happens during the boundary cycle (frame_start high), so the
    // new value lands inside the first blank slot and never mid-frame. A value accepted
    // during that same cycle is not yet pending and therefore waits a whole frame.
    assign load_ready = !pend_vld_q;
    assign accept     = load_valid && !pend_vld_q;
    assign copy       = pend_vld_q && ((state_q == IDLE) || fs_q);

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        active_d   = active_q;
        if (copy) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            pend_d     = load_data;
            pend_vld_d = 1'b1;
        end
    end

    // Outputs are computed from next-state values so the registered seg and selected
    // always describe the same slot.
    always_comb begin
        case (digit_d)
            2'd1:    nib = active_d[7:4];
            2'd2:    nib = active_d[11:8];
            default: nib = active_d[3:0];
        endcase
        lz_blank = blank_lz &&
                   (((digit_d == 2'd2) && (active_d[11:8] == 4'd0)) ||
                    ((digit_d == 2'd1) && (active_d[11:4] == 8'd0)));
        sel_d = 2'd3;
        seg_d = 7'h7F;
        if (state_d == SHOW) begin
            sel_d = digit_d;
            seg_d = lz_blank ? 7'h7F : decode(nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            digit_q    <= 2'd0;
            pend_q     <= 12'h000;
            pend_vld_q <= 1'b0;
            active_q   <= 12'h000;
            sel_q      <= 2'd3;
            seg_q      <= 7'h7F;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            active_q   <= active_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            fs_q       <= fs_d;
        end
    end

    assign selected    = sel_q;
    assign seg         = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Purpose : randomized + directed bench for display_scan_controller against an elapsed-time reference model.
// Latency : model pushes one expected output set per clock; monitor pops and compares on the falling edge.
// Backpressure: model tracks its own pending buffer to decide which offered loads are accepted.
module tb_display_scan_controller;

    localparam int R = 8;
    localparam int B = 2;
    localparam int FRAME = 3 * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        blank_lz = 1'b0;
    logic        load_valid = 1'b0;
    logic [11:0] load_data = 12'h000;
    logic        load_ready;
    logic [1:0]  selected;
    logic [6:0]  seg;
    logic        frame_start;

    display_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .selected   (selected),
        .seg        (seg),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [6:0] seg;
        logic       fs;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state: scan position is just the number of cycles since the scan started.
    bit          m_running = 1'b0;
    int          m_t = 0;
    bit          m_pend_vld = 1'b0;
    logic [11:0] m_pend = 12'h000;
    logic [11:0] m_active = 12'h000;

    function automatic logic [6:0] model_seg(input int d, input logic [11:0] v, input bit blz);
        logic [3:0] n;
        n = v[d*4 +: 4];
        if (blz && d == 2 && v[11:8] == 4'd0) return 7'h7F;
        if (blz && d == 1 && v[11:4] == 8'd0) return 7'h7F;
        if (n > 4'd9) return 7'h3F;
        return seg_tbl[n];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        exp_t e;
        bit   boundary;
        bit   copy;
        bit   accept;
        int   ph;
        int   dg;
        if (!rst_n) begin
            m_running  = 1'b0;
            m_t        = 0;
            m_pend_vld = 1'b0;
            m_pend     = 12'h000;
            m_active   = 12'h000;
            exp_q.delete();
            e = '{sel: 2'd3, seg: 7'h7F, fs: 1'b0, rdy: 1'b1};
            exp_q.push_back(e);
        end else begin
            boundary = m_running && (m_t % FRAME == 0);
            copy     = m_pend_vld && (!m_running || boundary);
            accept   = load_valid && !m_pend_vld;
            if (copy) begin
                m_active   = m_pend;
                m_pend_vld = 1'b0;
            end
            if (accept) begin
                m_pend     = load_data;
                m_pend_vld = 1'b1;
            end
            if (enable) begin
                m_t       = m_running ? m_t + 1 : 0;
                m_running = 1'b1;
            end else begin
                m_t       = 0;
                m_running = 1'b0;
            end
            e.rdy = !m_pend_vld;
            if (!m_running) begin
                e.sel = 2'd3;
                e.seg = 7'h7F;
                e.fs  = 1'b0;
            end else begin
                ph   = m_t % R;
                dg   = (m_t / R) % 3;
                e.fs = (m_t % FRAME == 0);
                if (ph < B) begin
                    e.sel = 2'd3;
                    e.seg = 7'h7F;
                end else begin
                    e.sel = 2'(dg);
                    e.seg = model_seg(dg, m_active, blank_lz);
                end
            end
            exp_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("selected",    {6'd0, selected},    {6'd0, e.sel});
            chk("seg",         {1'b0, seg},         {1'b0, e.seg});
            chk("frame_start", {7'd0, frame_start}, {7'd0, e.fs});
            chk("load_ready",  {7'd0, load_ready},  {7'd0, e.rdy});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [11:0] v);
        load_valid = 1'b1;
        load_data  = v;
        step(1);
        load_valid = 1'b0;
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;

        // Load while idle, then scan 1/2/3.
        offer(12'h123);
        step(2);
        enable = 1'b1;
        step(2 * FRAME + 5);

        // Mid-frame load: old value holds until the wrap.
        offer(12'h456);
        step(3 * FRAME);

        // Leading-zero blanking on and off.
        blank_lz = 1'b1;
        offer(12'h007);
        step(2 * FRAME);
        blank_lz = 1'b0;
        step(2 * FRAME);

        // Abort in the 3rd SHOW cycle of digit 1, then restart.
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(1);
        step(R + B + 2);
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(FRAME + 2);

        // Async reset mid-SHOW with a transfer pending.
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(5);
        offer(12'h999);
        step(8);
        rst_n  = 1'b0;
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        enable = 1'b1;
        step(FRAME + 4);

        // Non-BCD tens nibble.
        offer(12'h0B5);
        step(2 * FRAME);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            enable     = ($urandom_range(0, 63) != 0);
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = 12'($urandom);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            step(1);
        end
        load_valid = 1'b0;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
